// File: rtl/note_scheduler_if.sv
// Chord handshake between song reader and scheduler,
// plus the voice control bus the scheduler drives.
interface note_scheduler_if #(
  parameter int DUR_WIDTH  = 6,
  parameter int NOTE_WIDTH = 6,
  parameter int META_WIDTH = 3
);
  logic                  play;
  logic                  beat;
  logic                  new_note;
  logic [1:0]            num_notes;
  logic [NOTE_WIDTH-1:0] note1;
  logic [NOTE_WIDTH-1:0] note2;
  logic [NOTE_WIDTH-1:0] note3;
  logic [NOTE_WIDTH-1:0] note4;
  logic [META_WIDTH-1:0] metadata1;
  logic [META_WIDTH-1:0] metadata2;
  logic [META_WIDTH-1:0] metadata3;
  logic [META_WIDTH-1:0] metadata4;
  logic [DUR_WIDTH-1:0]  duration;
  logic                  note_done;
  logic [3:0]            voice_load;
  logic [NOTE_WIDTH-1:0] voice_note0;
  logic [NOTE_WIDTH-1:0] voice_note1;
  logic [NOTE_WIDTH-1:0] voice_note2;
  logic [NOTE_WIDTH-1:0] voice_note3;
  logic [META_WIDTH-1:0] voice_meta0;
  logic [META_WIDTH-1:0] voice_meta1;
  logic [META_WIDTH-1:0] voice_meta2;
  logic [META_WIDTH-1:0] voice_meta3;
  logic [3:0]            voice_active;
  logic                  busy;

  modport master (
    output play, beat, new_note, num_notes,
    output note1, note2, note3, note4,
    output metadata1, metadata2, metadata3, metadata4,
    output duration,
    input  note_done, voice_load, voice_active, busy,
    input  voice_note0, voice_note1, voice_note2, voice_note3,
    input  voice_meta0, voice_meta1, voice_meta2, voice_meta3
  );

  modport slave (
    input  play, beat, new_note, num_notes,
    input  note1, note2, note3, note4,
    input  metadata1, metadata2, metadata3, metadata4,
    input  duration,
    output note_done, voice_load, voice_active, busy,
    output voice_note0, voice_note1, voice_note2, voice_note3,
    output voice_meta0, voice_meta1, voice_meta2, voice_meta3
  );
endinterface

// File: rtl/note_scheduler.sv
// Chord sequencer: latches a chord, loads voices, counts
// the duration in beats, then releases and pulses note_done.
module note_scheduler #(
  parameter int DUR_WIDTH  = 6,
  parameter int NOTE_WIDTH = 6,
  parameter int META_WIDTH = 3
) (
  input logic              clk,
  input logic              reset,
  note_scheduler_if.slave  bus_if
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RELEASE
  } state_e;

  state_e                state_q;
  logic [DUR_WIDTH-1:0]  cnt_q;
  logic [DUR_WIDTH-1:0]  cnt_d;
  logic [DUR_WIDTH-1:0]  dur_q;
  logic [NOTE_WIDTH-1:0] note_q [4];
  logic [META_WIDTH-1:0] meta_q [4];
  logic [NOTE_WIDTH-1:0] in_note [4];
  logic [META_WIDTH-1:0] in_meta [4];
  logic [3:0]            sel_d;
  logic [3:0]            mask_d;
  logic [3:0]            load_q;
  logic [3:0]            active_q;
  logic                  done_q;
  logic                  busy_q;

  assign in_note[0] = bus_if.note1;
  assign in_note[1] = bus_if.note2;
  assign in_note[2] = bus_if.note3;
  assign in_note[3] = bus_if.note4;
  assign in_meta[0] = bus_if.metadata1;
  assign in_meta[1] = bus_if.metadata2;
  assign in_meta[2] = bus_if.metadata3;
  assign in_meta[3] = bus_if.metadata4;

  assign cnt_d = cnt_q + 1'b1;

  // sel: voices covered by num_notes; mask: those that are not rests
  always_comb begin
    sel_d  = '0;
    mask_d = '0;
    for (int i = 0; i < 4; i++) begin
      sel_d[i]  = (i <= int'(bus_if.num_notes));
      mask_d[i] = sel_d[i] && (in_note[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dur_q    <= '0;
      load_q   <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        note_q[i] <= '0;
        meta_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus_if.new_note) begin
            for (int i = 0; i < 4; i++) begin
              note_q[i] <= sel_d[i] ? in_note[i] : '0;
              meta_q[i] <= sel_d[i] ? in_meta[i] : '0;
            end
            dur_q    <= bus_if.duration;
            load_q   <= mask_d;
            active_q <= mask_d;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          load_q <= '0;
          cnt_q  <= '0;
          if (dur_q == '0) begin
            active_q <= '0;
            done_q   <= 1'b1;
            state_q  <= RELEASE;
          end else begin
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (bus_if.beat && bus_if.play) begin
            cnt_q <= cnt_d;
            if (cnt_d == dur_q) begin
              active_q <= '0;
              done_q   <= 1'b1;
              state_q  <= RELEASE;
            end
          end
        end
        RELEASE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.note_done    = done_q;
  assign bus_if.voice_load   = load_q;
  assign bus_if.voice_active = active_q;
  assign bus_if.busy         = busy_q;
  assign bus_if.voice_note0  = note_q[0];
  assign bus_if.voice_note1  = note_q[1];
  assign bus_if.voice_note2  = note_q[2];
  assign bus_if.voice_note3  = note_q[3];
  assign bus_if.voice_meta0  = meta_q[0];
  assign bus_if.voice_meta1  = meta_q[1];
  assign bus_if.voice_meta2  = meta_q[2];
  assign bus_if.voice_meta3  = meta_q[3];

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler; chord expectations
// are queued on new_note and popped in the LOAD cycle.
module tb_note_scheduler;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  typedef struct packed {
    logic [3:0]      mask;
    logic [3:0][5:0] note;
    logic [3:0][2:0] meta;
  } exp_t;

  exp_t sb_q[$];

  note_scheduler_if #(
    .DUR_WIDTH (6),
    .NOTE_WIDTH(6),
    .META_WIDTH(3)
  ) bus_if ();

  note_scheduler #(
    .DUR_WIDTH (6),
    .NOTE_WIDTH(6),
    .META_WIDTH(3)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus_if(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_beat();
    bus_if.beat = 1'b1;
    tick();
    bus_if.beat = 1'b0;
  endtask

  task automatic send(input logic [1:0] num,
                      input logic [3:0][5:0] n,
                      input logic [3:0][2:0] m,
                      input logic [5:0] dur);
    exp_t e;
    bus_if.num_notes = num;
    bus_if.note1 = n[0];
    bus_if.note2 = n[1];
    bus_if.note3 = n[2];
    bus_if.note4 = n[3];
    bus_if.metadata1 = m[0];
    bus_if.metadata2 = m[1];
    bus_if.metadata3 = m[2];
    bus_if.metadata4 = m[3];
    bus_if.duration = dur;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (i <= int'(num)) begin
        e.note[i] = n[i];
        e.meta[i] = m[i];
        e.mask[i] = (n[i] != 6'd0);
      end
    end
    sb_q.push_back(e);
    bus_if.new_note = 1'b1;
    tick();
    bus_if.new_note = 1'b0;
  endtask

  task automatic check_load(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_load"}, 32'(bus_if.voice_load), 32'(e.mask));
      chk({tag, "_active"}, 32'(bus_if.voice_active),
          32'(e.mask));
      chk({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, "_notes"},
          {8'd0, bus_if.voice_note3, bus_if.voice_note2,
           bus_if.voice_note1, bus_if.voice_note0},
          {8'd0, e.note});
      chk({tag, "_metas"},
          {20'd0, bus_if.voice_meta3, bus_if.voice_meta2,
           bus_if.voice_meta1, bus_if.voice_meta0},
          {20'd0, e.meta});
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus_if.play = 1'b1;
    bus_if.beat = 1'b0;
    bus_if.new_note = 1'b0;
    bus_if.num_notes = 2'd0;
    bus_if.note1 = '0;
    bus_if.note2 = '0;
    bus_if.note3 = '0;
    bus_if.note4 = '0;
    bus_if.metadata1 = '0;
    bus_if.metadata2 = '0;
    bus_if.metadata3 = '0;
    bus_if.metadata4 = '0;
    bus_if.duration = '0;
    idle(3);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_load", 32'(bus_if.voice_load), 32'd0);
    chk("rst_active", 32'(bus_if.voice_active), 32'd0);
    chk("rst_done", 32'(bus_if.note_done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single note, beats every 4 cycles
    send(2'd0, {6'd7, 6'd6, 6'd5, 6'd20},
         {3'd4, 3'd2, 3'd1, 3'd3}, 6'd3);
    check_load("single");
    idle(3);
    pulse_beat();
    idle(3);
    pulse_beat();
    chk("single_hold_active", 32'(bus_if.voice_active), 32'h1);
    chk("single_hold_load", 32'(bus_if.voice_load), 32'h0);
    idle(3);
    chk("single_early_done", 32'(bus_if.note_done), 32'd0);
    pulse_beat();
    chk("single_done", 32'(bus_if.note_done), 32'd1);
    chk("single_rel_active", 32'(bus_if.voice_active), 32'h0);
    tick();
    chk("single_done_1cyc", 32'(bus_if.note_done), 32'd0);
    chk("single_idle", 32'(bus_if.busy), 32'd0);
    chk("single_note_kept", 32'(bus_if.voice_note0), 32'd20);

    // four-note chord with a rest in voice 1
    send(2'd3, {6'd17, 6'd14, 6'd0, 6'd10},
         {3'd7, 3'd6, 3'd5, 3'd4}, 6'd2);
    check_load("chord");
    tick();
    pulse_beat();
    chk("chord_mid_done", 32'(bus_if.note_done), 32'd0);
    chk("chord_mid_active", 32'(bus_if.voice_active), 32'hd);
    pulse_beat();
    chk("chord_done", 32'(bus_if.note_done), 32'd1);
    tick();

    // pause: beats while play is low are ignored
    send(2'd1, {6'd0, 6'd0, 6'd40, 6'd30},
         {3'd0, 3'd0, 3'd2, 3'd1}, 6'd4);
    check_load("pause");
    tick();
    pulse_beat();
    pulse_beat();
    bus_if.play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulse_beat();
    end
    chk("pause_done", 32'(bus_if.note_done), 32'd0);
    chk("pause_active", 32'(bus_if.voice_active), 32'h3);
    bus_if.play = 1'b1;
    tick();
    pulse_beat();
    chk("resume_3rd", 32'(bus_if.note_done), 32'd0);
    pulse_beat();
    chk("resume_done", 32'(bus_if.note_done), 32'd1);
    tick();

    // zero duration: done two cycles after new_note
    send(2'd0, {6'd0, 6'd0, 6'd0, 6'd12},
         {3'd0, 3'd0, 3'd0, 3'd6}, 6'd0);
    check_load("dur0");
    chk("dur0_load_cyc", 32'(bus_if.note_done), 32'd0);
    tick();
    chk("dur0_done", 32'(bus_if.note_done), 32'd1);
    tick();
    chk("dur0_idle", 32'(bus_if.busy), 32'd0);

    // second new_note during HOLD is ignored
    send(2'd0, {6'd0, 6'd0, 6'd0, 6'd9},
         {3'd0, 3'd0, 3'd0, 3'd2}, 6'd2);
    check_load("ign");
    tick();
    bus_if.num_notes = 2'd3;
    bus_if.note1 = 6'd33;
    bus_if.duration = 6'd1;
    bus_if.new_note = 1'b1;
    tick();
    bus_if.new_note = 1'b0;
    chk("ign_note0", 32'(bus_if.voice_note0), 32'd9);
    chk("ign_load", 32'(bus_if.voice_load), 32'd0);
    pulse_beat();
    chk("ign_dur_kept", 32'(bus_if.note_done), 32'd0);
    pulse_beat();
    chk("ign_done", 32'(bus_if.note_done), 32'd1);
    tick();

    // beat in LOAD cycle is not counted
    send(2'd0, {6'd0, 6'd0, 6'd0, 6'd25},
         {3'd0, 3'd0, 3'd0, 3'd1}, 6'd1);
    check_load("ldbeat");
    pulse_beat();
    chk("ldbeat_nocount", 32'(bus_if.note_done), 32'd0);
    chk("ldbeat_busy", 32'(bus_if.busy), 32'd1);
    tick();
    pulse_beat();
    chk("ldbeat_done", 32'(bus_if.note_done), 32'd1);
    tick();

    // all-rest chord still waits and pulses note_done
    send(2'd2, {6'd0, 6'd0, 6'd0, 6'd0},
         {3'd0, 3'd3, 3'd2, 3'd1}, 6'd1);
    check_load("rest");
    tick();
    pulse_beat();
    chk("rest_done", 32'(bus_if.note_done), 32'd1);
    tick();

    // asynchronous reset mid-HOLD
    send(2'd1, {6'd0, 6'd0, 6'd11, 6'd22},
         {3'd0, 3'd0, 3'd5, 3'd6}, 6'd5);
    check_load("arst");
    tick();
    pulse_beat();
    rst_n = 1'b0;
    #1;
    chk("arst_active", 32'(bus_if.voice_active), 32'd0);
    chk("arst_busy", 32'(bus_if.busy), 32'd0);
    chk("arst_note0", 32'(bus_if.voice_note0), 32'd0);
    chk("arst_meta1", 32'(bus_if.voice_meta1), 32'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse_beat();
      chk("arst_no_done", 32'(bus_if.note_done), 32'd0);
    end
    chk("arst_idle", 32'(bus_if.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequences chord playback between the song reader and the four note-player voices. Accepts one chord per `new_note` strobe (up to four notes, shared duration and per-note metadata), loads each note into its own voice, counts the chord's duration in beat ticks, then releases the voices and returns a single-cycle `note_done` to the song reader. It is the only block that drives voice load/active controls, so the reader never talks to voices directly.

## Interface

Parameters:
- `DUR_WIDTH`, 6: width of duration and beat counter.
- `NOTE_WIDTH`, 6: note code width; code 0 means rest.
- `META_WIDTH`, 3: per-note metadata (harmonics) width.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  asynchronous, active-low reset.
- `play`  in  1  high = run; low = pause beat counting.
- `beat`  in  1  one-cycle tick per duration unit.
- `new_note`  in  1  one-cycle chord-valid strobe from song reader.
- `num_notes`  in  2  chord size minus one (0 = 1 note … 3 = 4 notes).
- `note1`..`note4`  in  NOTE_WIDTH each  chord notes.
- `metadata1`..`metadata4`  in  META_WIDTH each  per-note metadata.
- `duration`  in  DUR_WIDTH  chord length in beats.
- `note_done`  out  1  one-cycle pulse: chord finished.
- `voice_load`  out  4  one-hot-per-voice load strobe (bit i = voice i).
- `voice_note0`..`voice_note3`  out  NOTE_WIDTH each  latched note per voice.
- `voice_meta0`..`voice_meta3`  out  META_WIDTH each  latched metadata per voice.
- `voice_active`  out  4  voice i sounding.
- `busy`  out  1  high in any state except IDLE.

## Operation

- States: IDLE, LOAD, HOLD, RELEASE.
- IDLE: on `new_note`=1, latch all notes, metadata, `num_notes`, `duration`; go LOAD. `play` not required to accept.
- Latching: voice i (0..3) takes `note(i+1)`/`metadata(i+1)` if i ≤ `num_notes`, else note 0 / metadata 0.
- LOAD (1 cycle): `voice_load` bit i = 1 for every i ≤ `num_notes` whose note ≠ 0; `voice_active` set to the same mask. Clear beat counter. Next: RELEASE if latched duration = 0, else HOLD.
- HOLD: counter increments on each cycle with `beat`=1 and `play`=1. When the increment makes counter = latched duration, go RELEASE. `beat` while `play`=0 ignored; voices stay active while paused.
- RELEASE (1 cycle): `voice_active` = 0, `note_done` = 1; next IDLE.
- `new_note` in any state other than IDLE is ignored (no re-latch, no effect on counter).
- Counter is DUR_WIDTH bits; max duration 2^DUR_WIDTH−1 beats, never wraps because it stops at equality.
- Rests: note 0 voices never get a load strobe nor active bit; all-rest chord still waits full duration and pulses `note_done`.
- Reset (asserted low, any state, asynchronous): state IDLE, counter 0, all latched notes/metadata 0, `voice_load`=0, `voice_active`=0, `note_done`=0, `busy`=0. In-flight chord is discarded without `note_done`.

## Timing

- `new_note` sampled at edge t → LOAD during cycle t+1: `voice_load`, `voice_note*`, `voice_meta*` valid together; `voice_active` valid from t+1.
- HOLD from t+2. Beat in LOAD cycle is not counted.
- Duration D ≥ 1: D-th counted beat sampled at edge k → RELEASE during cycle k+1 (`note_done`=1), IDLE at k+2.
- Duration 0: RELEASE at t+2, `note_done` at t+2.
- Earliest next accept: `new_note` in cycle after RELEASE.
- `voice_note*`/`voice_meta*` hold their values after RELEASE until next LOAD.
- All outputs registered; no combinational input→output path.

## Test plan

- Reset: drive `reset`=0 mid-HOLD → all outputs 0 immediately; after release, IDLE, no `note_done`.
- Single note: `num_notes`=0, note1=20, duration=3, beats every 4 cycles → `voice_load`=0001, voice_note0=20, `note_done` one cycle after third counted beat, `voice_active` 0001 then 0000.
- Four-note chord with rest: notes 10,0,14,17, `num_notes`=3, duration=2 → `voice_load`=1101, `voice_active`=1101, voice_note1=0, done after 2 beats.
- Pause: duration=4, drop `play` after 2 beats, pulse 5 beats, raise `play` → counting resumes at 2, `note_done` only after 2 more beats.
- Duration 0 and ignored strobe: duration=0 → `note_done` exactly 2 cycles after `new_note`; separate chord with second `new_note` during HOLD → no re-latch, original duration honoured.
- Beat coincident with LOAD: `beat` in LOAD cycle, duration=1 → not counted; `note_done` follows the next beat.
